// File: rtl/dlx_mem_stage.sv
// DLX memory-access stage: byte/halfword/word loads and stores over a req/ack
// data-memory handshake, with a registered writeback bundle for the register file.
module dlx_mem_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [3:0]        ex_op,
  input  logic [ADDR_W-1:0] alu_res,
  input  logic [DATA_W-1:0] store_data,
  input  logic [4:0]        dest_reg,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              misalign
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                         OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;

  state_t            state_q, state_d;
  logic              req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d, op_q, op_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, wb_data_q, wb_data_d;
  logic [1:0]        off_q, off_d;
  logic [4:0]        dest_q, dest_d, wb_reg_q, wb_reg_d;
  logic              wb_valid_q, wb_valid_d, wb_we_q, wb_we_d, mis_q, mis_d;

  logic              accept, is_load, is_store, sz_byte, sz_half, sz_word, bad_align;
  logic [1:0]        off_in;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_val;

  assign ex_ready  = (state_q == IDLE);
  assign accept    = ex_valid & ex_ready;
  assign off_in    = alu_res[1:0];
  assign is_load   = (ex_op >= OP_LB) && (ex_op <= OP_LW);
  assign is_store  = (ex_op >= OP_SB) && (ex_op <= OP_SW);
  assign sz_byte   = (ex_op == OP_LB) || (ex_op == OP_LBU) || (ex_op == OP_SB);
  assign sz_half   = (ex_op == OP_LH) || (ex_op == OP_LHU) || (ex_op == OP_SH);
  assign sz_word   = (ex_op == OP_LW) || (ex_op == OP_SW);
  assign bad_align = (sz_half & off_in[0]) | (sz_word & (|off_in));

  // Big-endian lanes: offset 0 lives in bits 31:24.
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = dmem_rdata[31:24];
      2'd1:    ld_byte = dmem_rdata[23:16];
      2'd2:    ld_byte = dmem_rdata[15:8];
      default: ld_byte = dmem_rdata[7:0];
    endcase
    ld_half = off_q[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];
    case (op_q)
      OP_LB:   ld_val = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_val = {24'd0, ld_byte};
      OP_LH:   ld_val = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_val = {16'd0, ld_half};
      default: ld_val = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    op_d       = op_q;
    off_d      = off_q;
    dest_d     = dest_q;
    wb_reg_d   = wb_reg_q;
    wb_data_d  = wb_data_q;
    wb_valid_d = 1'b0;
    wb_we_d    = 1'b0;
    mis_d      = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        if (!(is_load || is_store)) begin
          wb_valid_d = 1'b1;
          wb_we_d    = |dest_reg;
          wb_reg_d   = dest_reg;
          wb_data_d  = DATA_W'(alu_res);
        end else if (bad_align) begin
          wb_valid_d = 1'b1;
          mis_d      = 1'b1;
        end else begin
          state_d = WAIT;
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = {alu_res[ADDR_W-1:2], 2'b00};
          op_d    = ex_op;
          off_d   = off_in;
          dest_d  = dest_reg;
          if (sz_byte)      be_d = 4'b1000 >> off_in;
          else if (sz_half) be_d = off_in[1] ? 4'b0011 : 4'b1100;
          else              be_d = 4'b1111;
          if (!is_store)    wdata_d = '0;
          else if (sz_byte) wdata_d = {4{store_data[7:0]}};
          else if (sz_half) wdata_d = {2{store_data[15:0]}};
          else              wdata_d = store_data;
        end
      end
      WAIT: if (dmem_ack) begin
        state_d    = IDLE;
        req_d      = 1'b0;
        we_d       = 1'b0;
        addr_d     = '0;
        be_d       = '0;
        wdata_d    = '0;
        wb_valid_d = 1'b1;
        wb_reg_d   = dest_q;
        if (we_q) begin
          wb_data_d = '0;
        end else begin
          wb_data_d = ld_val;
          wb_we_d   = |dest_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      op_q       <= '0;
      off_q      <= '0;
      dest_q     <= '0;
      wb_reg_q   <= '0;
      wb_data_q  <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      op_q       <= op_d;
      off_q      <= off_d;
      dest_q     <= dest_d;
      wb_reg_q   <= wb_reg_d;
      wb_data_q  <= wb_data_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      mis_q      <= mis_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_we      = wb_we_q;
  assign wb_reg     = wb_reg_q;
  assign wb_data    = wb_data_q;
  assign misalign   = mis_q;

endmodule

// File: tb/tb_dlx_mem_stage.sv
// Directed bench for dlx_mem_stage: PASS streaming, loads, stores, misalign, r0, reset in WAIT.
module tb_dlx_mem_stage;
  logic        clk = 1'b0, rst = 1'b1;
  logic        ex_valid = 1'b0, ex_ready;
  logic [3:0]  ex_op = '0;
  logic [31:0] alu_res = '0, store_data = '0;
  logic [4:0]  dest_reg = '0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_we, misalign;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  dlx_mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
    .alu_res(alu_res), .store_data(store_data), .dest_reg(dest_reg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .misalign(misalign));

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [4:0] d);
    ex_valid = 1'b1; ex_op = op; alu_res = a; dest_reg = d;
  endtask

  task automatic test_reset();
    total++;
    if ({dmem_req, dmem_we, wb_valid, wb_we, misalign, ex_ready} !== 6'b000001 ||
        dmem_addr !== 0 || dmem_be !== 0 || dmem_wdata !== 0 || wb_data !== 0 || wb_reg !== 0) begin
      bad++; $display("FAIL reset: req=%b ready=%b wbv=%b addr=%h want all 0, ready=1",
                      dmem_req, ex_ready, wb_valid, dmem_addr);
    end
    step(); rst = 1'b0; step();
  endtask

  task automatic test_pass_b2b();
    logic [31:0] vals [3] = '{32'd11, 32'd13, 32'd15};
    issue(4'd0, vals[0], 5'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (wb_valid !== 1'b1 || wb_we !== 1'b1 || wb_data !== vals[i] || wb_reg !== 5'(i + 1) ||
          ex_ready !== 1'b1 || dmem_req !== 1'b0) begin
        bad++; $display("FAIL pass_%0d: wbv=%b we=%b data=%0d reg=%0d ready=%b want 1 1 %0d %0d 1",
                        i, wb_valid, wb_we, wb_data, wb_reg, ex_ready, vals[i], i + 1);
      end
      if (i < 2) issue(4'd0, vals[i + 1], 5'(i + 2)); else ex_valid = 1'b0;
    end
    step();
    total++;
    if (wb_valid !== 1'b0 || wb_we !== 1'b0 || wb_data !== 32'd15) begin
      bad++; $display("FAIL pass_idle: wbv=%b we=%b data=%0d want 0 0 15", wb_valid, wb_we, wb_data);
    end
  endtask

  task automatic test_lb(input logic [3:0] op, input logic [31:0] exp);
    issue(op, 32'h102, 5'd4);
    step();
    ex_valid = 1'b0;
    total++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h100 || dmem_be !== 4'b0010 ||
        dmem_wdata !== 0 || ex_ready !== 1'b0) begin
      bad++; $display("FAIL lb_req: req=%b we=%b addr=%h be=%b ready=%b want 1 0 100 0010 0",
                      dmem_req, dmem_we, dmem_addr, dmem_be, ex_ready);
    end
    dmem_ack = 1'b1; dmem_rdata = 32'h1122_8344;
    step();
    dmem_ack = 1'b0;
    total++;
    if (wb_valid !== 1'b1 || wb_we !== 1'b1 || wb_reg !== 5'd4 || wb_data !== exp ||
        dmem_req !== 1'b0 || ex_ready !== 1'b1) begin
      bad++; $display("FAIL lb_wb op%0d: wbv=%b we=%b data=%h req=%b ready=%b want 1 1 %h 0 1",
                      op, wb_valid, wb_we, wb_data, dmem_req, ex_ready, exp);
    end
  endtask

  task automatic test_sh_delayed();
    issue(4'd7, 32'h206, 5'd9); store_data = 32'hDEAD_BEEF;
    step();
    ex_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h204 || dmem_be !== 4'b0011 ||
          dmem_wdata !== 32'hBEEF_BEEF || ex_ready !== 1'b0 || wb_valid !== 1'b0) begin
        bad++; $display("FAIL sh_wait_%0d: req=%b we=%b addr=%h be=%b wd=%h ready=%b want 1 1 204 0011 beefbeef 0",
                        i, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, ex_ready);
      end
      if (i == 2) dmem_ack = 1'b1;
      step();
    end
    dmem_ack = 1'b0;
    total++;
    if (wb_valid !== 1'b1 || wb_we !== 1'b0 || wb_data !== 0 || dmem_req !== 1'b0 || ex_ready !== 1'b1) begin
      bad++; $display("FAIL sh_wb: wbv=%b we=%b data=%h req=%b want 1 0 0 0", wb_valid, wb_we, wb_data, dmem_req);
    end
    dmem_ack = 1'b1;  // stray ack while idle must do nothing
    step();
    dmem_ack = 1'b0;
    total++;
    if (wb_valid !== 1'b0 || dmem_req !== 1'b0 || ex_ready !== 1'b1) begin
      bad++; $display("FAIL stray_ack: wbv=%b req=%b ready=%b want 0 0 1", wb_valid, dmem_req, ex_ready);
    end
  endtask

  task automatic test_misalign(input logic [3:0] op, input logic [31:0] a);
    issue(op, a, 5'd3);
    step();
    ex_valid = 1'b0;
    total++;
    if (dmem_req !== 1'b0 || misalign !== 1'b1 || wb_valid !== 1'b1 || wb_we !== 1'b0 || ex_ready !== 1'b1) begin
      bad++; $display("FAIL misalign_%h: req=%b mis=%b wbv=%b we=%b want 0 1 1 0", a, dmem_req, misalign, wb_valid, wb_we);
    end
    step();
    total++;
    if (misalign !== 1'b0 || wb_valid !== 1'b0 || dmem_req !== 1'b0) begin
      bad++; $display("FAIL misalign_pulse_%h: mis=%b wbv=%b req=%b want 0 0 0", a, misalign, wb_valid, dmem_req);
    end
  endtask

  task automatic test_r0();
    issue(4'd5, 32'h400, 5'd0);
    step();
    ex_valid = 1'b0;
    total++;
    if (dmem_req !== 1'b1 || dmem_addr !== 32'h400 || dmem_be !== 4'b1111) begin
      bad++; $display("FAIL r0_req: req=%b addr=%h be=%b want 1 400 1111", dmem_req, dmem_addr, dmem_be);
    end
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    step();
    dmem_ack = 1'b0;
    total++;
    if (wb_valid !== 1'b1 || wb_we !== 1'b0 || wb_data !== 32'h1234_5678) begin
      bad++; $display("FAIL r0_wb: wbv=%b we=%b data=%h want 1 0 12345678", wb_valid, wb_we, wb_data);
    end
  endtask

  task automatic test_reset_wait();
    issue(4'd5, 32'h500, 5'd7);
    step();
    ex_valid = 1'b0;
    step(); step();
    rst = 1'b1; #1;
    total++;
    if (dmem_req !== 1'b0 || ex_ready !== 1'b1 || wb_valid !== 1'b0) begin
      bad++; $display("FAIL rst_wait: req=%b ready=%b wbv=%b want 0 1 0", dmem_req, ex_ready, wb_valid);
    end
    step();
    rst = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hAAAA_AAAA;  // late ack for the abandoned load
    issue(4'd0, 32'd5, 5'd6);
    step();
    ex_valid = 1'b0; dmem_ack = 1'b0;
    total++;
    if (wb_valid !== 1'b1 || wb_we !== 1'b1 || wb_data !== 32'd5 || wb_reg !== 5'd6 || dmem_req !== 1'b0) begin
      bad++; $display("FAIL rst_pass: wbv=%b we=%b data=%h reg=%0d want 1 1 5 6", wb_valid, wb_we, wb_data, wb_reg);
    end
    step();
    total++;
    if (wb_valid !== 1'b0 || wb_data !== 32'd5) begin
      bad++; $display("FAIL rst_stale: wbv=%b data=%h want 0 5", wb_valid, wb_data);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_pass_b2b();
    test_lb(4'd1, 32'hFFFF_FF83);
    test_lb(4'd2, 32'h0000_0083);
    test_sh_delayed();
    test_misalign(4'd5, 32'h301);
    test_misalign(4'd3, 32'h303);
    test_r0();
    test_reset_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
